alu_rf_sequencer: RTL and testbench



---
 rtl/alu_rf_sequencer_if.sv | 25 ++
 rtl/alu_rf_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_rf_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rf_sequencer_if.sv
// Command channel into alu_rf_sequencer: valid/ready handshake plus the
// register-to-register (or register-immediate) instruction fields.
interface alu_rf_sequencer_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic              cmd_use_imm;
    logic [WIDTH-1:0]  cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_use_imm, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_use_imm, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/alu_rf_sequencer.sv
// Multi-cycle sequencer: reads A then B through the single register-file read
// port, drives the ALU, latches the result and writes it back.
module alu_rf_sequencer #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    alu_rf_sequencer_if.slave cmd,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [WIDTH-1:0]  rf_rd_data,
    output logic [ADDR_W-1:0] rf_we_addr,
    output logic [WIDTH-1:0]  rf_we_data,
    output logic              rf_we,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [2:0]        alu_control,
    input  logic [WIDTH-1:0]  alu_res,
    output logic              done,
    output logic              err,
    output logic [WIDTH-1:0]  result,
    output logic [CNT_W-1:0]  retired
);
    localparam int unsigned OP_W = 3;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] READ_A = 3'd1;
    localparam logic [2:0] READ_B = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;

    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'b111;

    logic [2:0]        state;
    logic [2:0]        state_nxt;

    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic              use_imm_q;
    logic [WIDTH-1:0]  imm_q;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;

    // Only IDLE accepts; gating with reset keeps ready low while reset is held.
    assign cmd.cmd_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus all state-decoded outputs; everything idles at 0.
    always_comb begin
        state_nxt   = state;
        rf_rd_addr  = '0;
        rf_we_addr  = '0;
        rf_we_data  = '0;
        rf_we       = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    state_nxt = READ_A;
                end
            end
            READ_A: begin
                rf_rd_addr = src_a_q;
                state_nxt  = use_imm_q ? EXEC : READ_B;
            end
            READ_B: begin
                rf_rd_addr = src_b_q;
                state_nxt  = EXEC;
            end
            EXEC: begin
                alu_a       = opa;
                alu_b       = opb;
                alu_control = op_q;
                state_nxt   = WRITE;
            end
            WRITE: begin
                rf_we_addr = dst_q;
                rf_we_data = result;
                rf_we      = (op_q != OP_ILLEGAL);
                done       = 1'b1;
                err        = (op_q == OP_ILLEGAL);
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, operand capture, result latch and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            dst_q     <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            opa       <= '0;
            opb       <= '0;
            result    <= '0;
            retired   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_q      <= cmd.cmd_op;
                        dst_q     <= cmd.cmd_dst;
                        src_a_q   <= cmd.cmd_src_a;
                        src_b_q   <= cmd.cmd_src_b;
                        use_imm_q <= cmd.cmd_use_imm;
                        imm_q     <= cmd.cmd_imm;
                    end
                end
                READ_A: begin
                    opa <= rf_rd_data;
                    if (use_imm_q) begin
                        opb <= imm_q;
                    end
                end
                READ_B: begin
                    opb <= rf_rd_data;
                end
                EXEC: begin
                    result <= alu_res;
                end
                WRITE: begin
                    if (op_q != OP_ILLEGAL) begin
                        retired <= retired + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Bench for alu_rf_sequencer: behavioural register file and ALU around the DUT,
// a directed vector table, hand sequences and a randomized model comparison.
module tb_alu_rf_sequencer;
    logic       clk;
    logic       reset;
    logic [1:0] rf_rd_addr;
    logic [3:0] rf_rd_data;
    logic [1:0] rf_we_addr;
    logic [3:0] rf_we_data;
    logic       rf_we;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_control;
    logic [3:0] alu_res;
    logic       done;
    logic       err;
    logic [3:0] result;
    logic [7:0] retired;

    int tests = 0;
    int fails = 0;

    alu_rf_sequencer_if #(.WIDTH(4), .ADDR_W(2)) bus ();

    alu_rf_sequencer #(.WIDTH(4), .ADDR_W(2), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (bus.slave),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .rf_we_addr  (rf_we_addr),
        .rf_we_data  (rf_we_data),
        .rf_we       (rf_we),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_res     (alu_res),
        .done        (done),
        .err         (err),
        .result      (result),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU behaviour from the op table, using plain integer arithmetic.
    function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, sa, sb, r;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        case (op)
            3'd0:    r = ia & ib;
            3'd1:    r = 15 - (ia & ib);
            3'd2:    r = ia | ib;
            3'd3:    r = 15 - (ia | ib);
            3'd4:    r = (ia + ib) % 16;
            3'd5:    r = (ia - ib + 16) % 16;
            3'd6:    r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        return 4'(r);
    endfunction

    logic [3:0] rf_mem [4] = '{default: 4'd0};
    assign rf_rd_data = rf_mem[rf_rd_addr];
    always @(negedge clk) begin
        if (rf_we) rf_mem[rf_we_addr] <= rf_we_data;
    end
    assign alu_res = ref_alu(alu_control, alu_a, alu_b);

    logic [3:0] mregs [4] = '{default: 4'd0};
    logic [7:0] mretired = 8'd0;
    int         total_legal = 0;

    typedef struct {
        logic [2:0] op;
        logic [1:0] dst;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       use_imm;
        logic [3:0] imm;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_cmd(input vec_t c);
        bus.cmd_op      = c.op;
        bus.cmd_dst     = c.dst;
        bus.cmd_src_a   = c.src_a;
        bus.cmd_src_b   = c.src_b;
        bus.cmd_use_imm = c.use_imm;
        bus.cmd_imm     = c.imm;
        bus.cmd_valid   = 1'b1;
    endtask

    // Issue one command (caller sits at posedge+1) and check its completion.
    task automatic run_cmd(input vec_t c);
        int  k;
        bit  seen;
        bit  we_early;
        bit  legal;
        legal = (c.op != 3'b111);
        drive_cmd(c);
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("accept_ready", int'(bus.cmd_ready), 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        k = 1; seen = 1'b0; we_early = 1'b0;
        while (!seen && k <= 8) begin
            if (done) seen = 1'b1;
            else begin
                if (rf_we) we_early = 1'b1;
                @(posedge clk); #1; k++;
            end
        end
        check("done_seen", int'(seen), 1);
        if (seen) begin
            check("latency", k, c.use_imm ? 3 : 4);
            check("err", int'(err), legal ? 0 : 1);
            check("rf_we", int'(rf_we), legal ? 1 : 0);
            check("we_early", int'(we_early), 0);
            if (legal) begin
                check("we_addr", int'(rf_we_addr), int'(c.dst));
                check("we_data", int'(rf_we_data), int'(c.exp));
                check("result", int'(result), int'(c.exp));
                mregs[c.dst] = c.exp;
                mretired     = mretired + 8'd1;
                total_legal++;
            end
        end
        @(posedge clk); #1;
        check("ready_after", int'(bus.cmd_ready), 1);
        check("done_drop", int'(done), 0);
        check("retired", int'(retired), int'(mretired));
        check("rf_content", int'(rf_mem[c.dst]), int'(mregs[c.dst]));
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] a,
                                input logic [1:0] b, input logic ui, input logic [3:0] imm,
                                input logic [3:0] exp);
        vec_t v;
        v.op = op; v.dst = dst; v.src_a = a; v.src_b = b; v.use_imm = ui; v.imm = imm; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t rand_cmd(input bit force_imm_legal);
        vec_t v;
        v.op      = force_imm_legal ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 7));
        v.dst     = 2'($urandom_range(0, 3));
        v.src_a   = 2'($urandom_range(0, 3));
        v.src_b   = 2'($urandom_range(0, 3));
        v.use_imm = force_imm_legal ? 1'b1 : 1'($urandom_range(0, 1));
        v.imm     = 4'($urandom_range(0, 15));
        v.exp     = ref_alu(v.op, mregs[v.src_a], v.use_imm ? v.imm : mregs[v.src_b]);
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  k;
        bit  seen;
        vec_t c;

        vecs[0]  = mk(3'b010, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5,  4'd5);
        vecs[1]  = mk(3'b010, 2'd2, 2'd0, 2'd0, 1'b1, 4'd3,  4'd3);
        vecs[2]  = mk(3'b100, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0,  4'd8);
        vecs[3]  = mk(3'b010, 2'd1, 2'd0, 2'd0, 1'b1, 4'd9,  4'd9);
        vecs[4]  = mk(3'b100, 2'd3, 2'd1, 2'd1, 1'b0, 4'd0,  4'd2);
        vecs[5]  = mk(3'b010, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3,  4'd3);
        vecs[6]  = mk(3'b010, 2'd2, 2'd0, 2'd0, 1'b1, 4'd5,  4'd5);
        vecs[7]  = mk(3'b101, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0,  4'd14);
        vecs[8]  = mk(3'b110, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0,  4'd1);
        vecs[9]  = mk(3'b110, 2'd3, 2'd2, 2'd1, 1'b0, 4'd0,  4'd0);
        vecs[10] = mk(3'b010, 2'd1, 2'd0, 2'd0, 1'b1, 4'd8,  4'd8);
        vecs[11] = mk(3'b010, 2'd2, 2'd0, 2'd0, 1'b1, 4'd7,  4'd7);
        vecs[12] = mk(3'b110, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0,  4'd1);
        vecs[13] = mk(3'b110, 2'd3, 2'd2, 2'd1, 1'b0, 4'd0,  4'd0);
        vecs[14] = mk(3'b111, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0,  4'd0);
        vecs[15] = mk(3'b000, 2'd3, 2'd1, 2'd0, 1'b1, 4'd12, 4'd8);
        vecs[16] = mk(3'b001, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0,  4'd15);
        vecs[17] = mk(3'b011, 2'd3, 2'd2, 2'd0, 1'b1, 4'd8,  4'd0);

        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0; bus.cmd_src_a = '0;
        bus.cmd_src_b = '0; bus.cmd_use_imm = 1'b0; bus.cmd_imm = '0;

        // Reset state.
        #3;
        check("rst_ready", int'(bus.cmd_ready), 0);
        check("rst_rf_we", int'(rf_we), 0);
        check("rst_done", int'(done), 0);
        check("rst_retired", int'(retired), 0);
        check("rst_result", int'(result), 0);
        check("rst_outputs", int'({rf_rd_addr, rf_we_addr, rf_we_data, alu_a, alu_b, alu_control}), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_ready", int'(bus.cmd_ready), 1);

        foreach (vecs[i]) run_cmd(vecs[i]);

        // Back-to-back with cmd_valid held high; second reads the first's dst.
        drive_cmd(mk(3'b010, 2'd2, 2'd0, 2'd0, 1'b1, 4'd7, 4'd7));
        @(posedge clk); #1;
        k = 1; seen = 1'b0;
        while (!seen && k <= 8) begin
            if (done) seen = 1'b1;
            else begin
                check("b2b_busy_ready", int'(bus.cmd_ready), 0);
                @(posedge clk); #1; k++;
            end
        end
        check("b2b1_latency", k, 3);
        check("b2b1_data", int'(rf_we_data), 7);
        check("b2b1_busy_ready", int'(bus.cmd_ready), 0);
        drive_cmd(mk(3'b100, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 4'd14));
        @(posedge clk); #1;
        check("b2b_idle_ready", int'(bus.cmd_ready), 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        k = 1; seen = 1'b0;
        while (!seen && k <= 8) begin
            if (done) seen = 1'b1;
            else begin
                check("b2b_busy_ready", int'(bus.cmd_ready), 0);
                @(posedge clk); #1; k++;
            end
        end
        check("b2b2_latency", k, 4);
        check("b2b2_addr", int'(rf_we_addr), 0);
        check("b2b2_data", int'(rf_we_data), 14);
        mregs[2] = 4'd7; mregs[0] = 4'd14; mretired = mretired + 8'd2; total_legal += 2;
        @(posedge clk); #1;
        check("b2b_retired", int'(retired), int'(mretired));

        // Randomized commands against the model, including illegal ops.
        for (int n = 0; n < 60; n++) begin
            c = rand_cmd(1'b0);
            run_cmd(c);
        end

        // Keep going until the retired counter has wrapped past 255.
        for (int n = 0; n < 400 && total_legal < 262; n++) begin
            c = rand_cmd(1'b1);
            run_cmd(c);
        end
        check("wrap_reached", int'(total_legal >= 262), 1);

        // Reset in the middle of READ_B aborts the instruction.
        drive_cmd(mk(3'b100, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0, 4'd0));
        check("mid_accept_ready", int'(bus.cmd_ready), 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("mid_read_a_addr", int'(rf_rd_addr), 1);
        @(posedge clk); #1;
        check("mid_read_b_addr", int'(rf_rd_addr), 2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", int'(bus.cmd_ready), 0);
        check("mid_rst_rf_we", int'(rf_we), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_retired", int'(retired), 0);
        check("mid_rst_result", int'(result), 0);
        check("mid_rst_outputs", int'({rf_rd_addr, rf_we_addr, rf_we_data, alu_a, alu_b, alu_control}), 0);
        @(posedge clk); #1;
        check("mid_rst_hold_we", int'(rf_we), 0);
        reset = 1'b0;
        mretired = 8'd0;
        #1;
        check("mid_post_ready", int'(bus.cmd_ready), 1);
        check("mid_post_retired", int'(retired), 0);
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (done || rf_we) seen = 1'b1;
        end
        check("mid_no_completion", int'(seen), 0);
        check("mid_rf_untouched", int'(rf_mem[3]), int'(mregs[3]));

        c = rand_cmd(1'b1);
        run_cmd(c);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
